uart_port: RTL

//  Responder for the exec unit's UART request interface (wenable/wsz/wd/wdone, renable/rsz/rd/rdone).

---
 rtl/uart_port_if.sv | 22 ++
 rtl/uart_port.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/uart_port_if.sv
// Word-level UART request bus between the exec unit (master) and uart_port (slave).
// Each request is a one-cycle strobe and is answered by a one-cycle done pulse.
interface uart_port_if;
  logic        uart_wenable;
  logic [1:0]  uart_wsz;
  logic [31:0] uart_wd;
  logic        uart_wdone;
  logic        uart_renable;
  logic [1:0]  uart_rsz;
  logic [31:0] uart_rd;
  logic        uart_rdone;

  modport master (
    output uart_wenable, uart_wsz, uart_wd, uart_renable, uart_rsz,
    input  uart_wdone, uart_rd, uart_rdone
  );

  modport slave (
    input  uart_wenable, uart_wsz, uart_wd, uart_renable, uart_rsz,
    output uart_wdone, uart_rd, uart_rdone
  );
endinterface

// File: rtl/uart_port.sv
// Word <-> byte adapter between the core's UART requests and the serial byte blocks.
// Writes are split MSB-first into a TX byte FIFO; reads are assembled from an RX byte FIFO.
module uart_port #(
  parameter int TX_DEPTH_LOG2 = 4,
  parameter int RX_DEPTH_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rstn,
  uart_port_if.slave        bus,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_overflow
);

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;
  localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;

  logic [7:0]             tx_mem [TX_DEPTH];
  logic [TX_DEPTH_LOG2:0] tx_wptr, tx_rptr;
  logic                   tx_full, tx_empty, tx_push, tx_pop;
  logic [7:0]             tx_byte;

  logic [7:0]             rx_mem [RX_DEPTH];
  logic [RX_DEPTH_LOG2:0] rx_wptr, rx_rptr;
  logic                   rx_full, rx_empty, rx_push, rx_pop;
  logic [7:0]             rx_head;

  state_t      state, state_n;
  logic [2:0]  cnt, cnt_n;
  logic [31:0] wd_q, wd_n;
  logic [31:0] acc, acc_n;
  logic        rd_pend, rd_pend_n;
  logic [1:0]  rsz_pend, rsz_pend_n;
  logic        wdone_n, rdone_n;
  logic [31:0] rd_n;
  logic [1:0]  byte_sel;

  // Full when the wrap bits differ and the index bits match.
  assign tx_empty = (tx_wptr == tx_rptr);
  assign tx_full  = (tx_wptr[TX_DEPTH_LOG2] != tx_rptr[TX_DEPTH_LOG2]) &&
                    (tx_wptr[TX_DEPTH_LOG2-1:0] == tx_rptr[TX_DEPTH_LOG2-1:0]);
  assign rx_empty = (rx_wptr == rx_rptr);
  assign rx_full  = (rx_wptr[RX_DEPTH_LOG2] != rx_rptr[RX_DEPTH_LOG2]) &&
                    (rx_wptr[RX_DEPTH_LOG2-1:0] == rx_rptr[RX_DEPTH_LOG2-1:0]);

  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_mem[tx_rptr[TX_DEPTH_LOG2-1:0]];
  assign tx_pop   = tx_valid & tx_ready;
  assign rx_head  = rx_mem[rx_rptr[RX_DEPTH_LOG2-1:0]];
  assign rx_push  = rx_valid & ~rx_full;

  // cnt counts down from the byte count, so cnt-1 selects the next byte MSB-first.
  assign byte_sel = cnt[1:0] - 2'd1;
  assign tx_byte  = wd_q[{byte_sel, 3'b000} +: 8];

  // NOTE: FIFO storage has no reset; the pointers alone define its contents.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr[TX_DEPTH_LOG2-1:0]] <= tx_byte;
    if (rx_push) rx_mem[rx_wptr[RX_DEPTH_LOG2-1:0]] <= rx_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_wptr     <= '0;
      tx_rptr     <= '0;
      rx_wptr     <= '0;
      rx_rptr     <= '0;
      rx_overflow <= 1'b0;
    end else begin
      if (tx_push)             tx_wptr     <= tx_wptr + 1'b1;
      if (tx_pop)              tx_rptr     <= tx_rptr + 1'b1;
      if (rx_push)             rx_wptr     <= rx_wptr + 1'b1;
      if (rx_pop)              rx_rptr     <= rx_rptr + 1'b1;
      if (rx_valid && rx_full) rx_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      cnt            <= '0;
      wd_q           <= '0;
      acc            <= '0;
      rd_pend        <= 1'b0;
      rsz_pend       <= '0;
      bus.uart_wdone <= 1'b0;
      bus.uart_rdone <= 1'b0;
      bus.uart_rd    <= '0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      wd_q           <= wd_n;
      acc            <= acc_n;
      rd_pend        <= rd_pend_n;
      rsz_pend       <= rsz_pend_n;
      bus.uart_wdone <= wdone_n;
      bus.uart_rdone <= rdone_n;
      bus.uart_rd    <= rd_n;
    end
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no latch is inferred.
    state_n    = state;
    cnt_n      = cnt;
    wd_n       = wd_q;
    acc_n      = acc;
    rd_pend_n  = rd_pend;
    rsz_pend_n = rsz_pend;
    tx_push    = 1'b0;
    rx_pop     = 1'b0;
    wdone_n    = 1'b0;
    rdone_n    = 1'b0;
    rd_n       = bus.uart_rd;
    case (state)
      IDLE: begin
        if (bus.uart_wenable) begin
          wd_n    = bus.uart_wd;
          cnt_n   = {1'b0, bus.uart_wsz} + 3'd1;
          state_n = WR;
          if (bus.uart_renable) begin
            rd_pend_n  = 1'b1;
            rsz_pend_n = bus.uart_rsz;
          end
        end else if (bus.uart_renable) begin
          cnt_n   = {1'b0, bus.uart_rsz} + 3'd1;
          acc_n   = '0;
          state_n = RD;
        end
      end
      WR: begin
        if (!tx_full) begin
          tx_push = 1'b1;
          cnt_n   = cnt - 3'd1;
          if (cnt == 3'd1) begin
            wdone_n = 1'b1;
            // A read that arrived with this write starts as soon as the write is queued.
            if (rd_pend) begin
              rd_pend_n = 1'b0;
              cnt_n     = {1'b0, rsz_pend} + 3'd1;
              acc_n     = '0;
              state_n   = RD;
            end else begin
              state_n = IDLE;
            end
          end
        end
      end
      RD: begin
        if (!rx_empty) begin
          rx_pop = 1'b1;
          acc_n  = {acc[23:0], rx_head};
          cnt_n  = cnt - 3'd1;
          if (cnt == 3'd1) begin
            rd_n    = acc_n;
            rdone_n = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
